// File: rtl/ds_line_wr_ctrl_if.sv
// Pixel-stream and FIFO write-port bundle for the downsample-path line write controller.
// The master side is the controller; the slave side is the downsampler plus FIFO environment.
interface ds_line_wr_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             sof;
    logic             pix_valid;
    logic [WIDTH-1:0] pix_data;
    logic             pix_ready;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [WIDTH-1:0] fifo_wr_data;

    modport master (
        input  sof, pix_valid, pix_data, fifo_full,
        output pix_ready, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        output sof, pix_valid, pix_data, fifo_full,
        input  pix_ready, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/ds_line_wr_ctrl.sv
// Write-side sequencer for the downsample-path async line FIFO (wr_clk domain): writes one
// line at a time, tracks completed-but-unconsumed lines and holds off new lines at the limit.
module ds_line_wr_ctrl #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CW          = 11,
    parameter int unsigned MAX_PENDING = 4,
    parameter int unsigned PW          = 3
) (
    input  logic                 wr_clk,
    input  logic                 wr_rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CW-1:0]        width_new,
    input  logic [CW-1:0]        height_new,
    ds_line_wr_ctrl_if.master    bus,
    input  logic                 line_consumed,
    output logic                 line_done,
    output logic                 frame_done,
    output logic                 busy,
    output logic [PW-1:0]        pending,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_LINE_WAIT,
        S_WRITE
    } state_t;

    localparam logic [PW:0] LP_MAX = (PW+1)'(MAX_PENDING);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_width;
    logic [CW-1:0]    r_height;
    logic [CW-1:0]    r_pix_cnt;
    logic [CW-1:0]    r_line_cnt;
    logic [PW-1:0]    r_pending;
    logic             r_line_done;
    logic             r_frame_done;
    logic             r_err;

    logic             w_ready;
    logic             w_xfer;
    logic             w_sof_pix;
    logic             w_cfg_ok;
    logic             w_pix_end;
    logic             w_line_end;
    logic             w_last_pix;
    logic             w_first_pix;
    logic             w_inc;
    logic             w_dec;
    logic             w_sof_err;
    logic [PW:0]      w_pend_eff;
    logic [WIDTH-1:0] w_wr_data;

    assign w_sof_pix   = bus.pix_valid && bus.sof;
    assign w_cfg_ok    = (|width_new) && (|height_new);
    assign w_pix_end   = (r_pix_cnt == r_width - CW'(1));
    assign w_line_end  = (r_line_cnt == r_height - CW'(1));
    assign w_first_pix = (r_pix_cnt == '0) && (r_line_cnt == '0);
    // A line whose line_done is still in flight is counted before pending catches up.
    assign w_pend_eff  = {1'b0, r_pending} + (PW+1)'(r_line_done);

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && w_cfg_ok)
                    w_state_nxt = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                w_ready = !w_sof_pix;
                if (w_sof_pix)
                    w_state_nxt = S_LINE_WAIT;
            end
            S_LINE_WAIT: begin
                if (w_pend_eff < LP_MAX)
                    w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_ready = !bus.fifo_full;
                if (w_last_pix)
                    w_state_nxt = w_line_end ? S_IDLE : S_LINE_WAIT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort)
            w_state_nxt = S_IDLE;
    end

    assign w_xfer     = (r_state == S_WRITE) && bus.pix_valid && w_ready && !abort;
    assign w_last_pix = w_xfer && w_pix_end;

    // The held sof pixel (pixel 0 of line 0) legitimately carries sof into LINE_WAIT/WRITE.
    assign w_sof_err  = ((r_state == S_LINE_WAIT) || (r_state == S_WRITE)) &&
                        w_sof_pix && !w_first_pix;
    assign w_inc      = r_line_done;
    assign w_dec      = line_consumed;

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            r_state      <= S_IDLE;
            r_width      <= '0;
            r_height     <= '0;
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
            r_pending    <= '0;
            r_line_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_line_done  <= w_last_pix;
            r_frame_done <= w_last_pix && w_line_end;

            if (abort) begin
                r_pix_cnt  <= '0;
                r_line_cnt <= '0;
            end else if ((r_state == S_IDLE) && start && w_cfg_ok) begin
                r_width    <= width_new;
                r_height   <= height_new;
            end else if (w_xfer) begin
                if (w_pix_end) begin
                    r_pix_cnt  <= '0;
                    r_line_cnt <= w_line_end ? '0 : r_line_cnt + CW'(1);
                end else begin
                    r_pix_cnt  <= r_pix_cnt + CW'(1);
                end
            end

            if (w_inc && !w_dec)
                r_pending <= r_pending + PW'(1);
            else if (w_dec && !w_inc && (r_pending != '0))
                r_pending <= r_pending - PW'(1);

            if (((r_state == S_IDLE) && start && !abort && !w_cfg_ok) ||
                w_sof_err || (w_dec && !w_inc && (r_pending == '0)))
                r_err <= 1'b1;
        end
    end

    assign w_wr_data        = bus.pix_data;
    assign bus.pix_ready    = w_ready;
    assign bus.fifo_wr_en   = w_xfer;
    assign bus.fifo_wr_data = w_wr_data;
    assign line_done        = r_line_done;
    assign frame_done       = r_frame_done;
    assign busy             = (r_state != S_IDLE);
    assign pending          = r_pending;
    assign err              = r_err;

endmodule

// File: tb/tb_ds_line_wr_ctrl.sv
// Directed bench for ds_line_wr_ctrl: instance A (MAX_PENDING=4) runs the cycle tables,
// instance B (MAX_PENDING=2) exercises the credit stall and the zero-configuration start.
module tb_ds_line_wr_ctrl;

    logic        wr_clk = 1'b0;
    logic        wr_rstn = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
    logic [10:0] width_new = '0, height_new = '0;
    logic        sof = 1'b0, pix_valid = 1'b0, fifo_full = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        line_consumed_a = 1'b0, line_consumed_b = 1'b0;
    logic        line_done_a, frame_done_a, busy_a, err_a;
    logic        line_done_b, frame_done_b, busy_b, err_b;
    logic [2:0]  pending_a, pending_b;

    int checks = 0;
    int failures = 0;
    int nb = 0;
    int fd_b = 0;

    always #5 wr_clk = ~wr_clk;

    ds_line_wr_ctrl_if #(.WIDTH(8)) ifa ();
    ds_line_wr_ctrl_if #(.WIDTH(8)) ifb ();

    assign ifa.sof = sof;        assign ifb.sof = sof;
    assign ifa.pix_valid = pix_valid; assign ifb.pix_valid = pix_valid;
    assign ifa.pix_data = pix_data;   assign ifb.pix_data = pix_data;
    assign ifa.fifo_full = fifo_full; assign ifb.fifo_full = fifo_full;

    ds_line_wr_ctrl #(.WIDTH(8), .CW(11), .MAX_PENDING(4), .PW(3)) dut_a (
        .wr_clk(wr_clk), .wr_rstn(wr_rstn), .start(start_a), .abort(abort),
        .width_new(width_new), .height_new(height_new), .bus(ifa),
        .line_consumed(line_consumed_a), .line_done(line_done_a), .frame_done(frame_done_a),
        .busy(busy_a), .pending(pending_a), .err(err_a)
    );

    ds_line_wr_ctrl #(.WIDTH(8), .CW(11), .MAX_PENDING(2), .PW(3)) dut_b (
        .wr_clk(wr_clk), .wr_rstn(wr_rstn), .start(start_b), .abort(abort),
        .width_new(width_new), .height_new(height_new), .bus(ifb),
        .line_consumed(line_consumed_b), .line_done(line_done_b), .frame_done(frame_done_b),
        .busy(busy_b), .pending(pending_b), .err(err_b)
    );

    typedef struct {
        int   w, h;
        logic st, sf, vl;
        int   d;
        logic fl, cn, ab;
        logic rdy, wr;
        int   wd;
        logic ld, fd, bs;
        int   pn;
        logic er;
    } vec_t;

    vec_t vecs[$];
    int   cfg_w = 0, cfg_h = 0;

    task automatic v(input logic st, sf, vl, input int d, input logic fl, cn, ab,
                     input logic rdy, wr, input int wd, input logic ld, fd, bs,
                     input int pn, input logic er);
        vec_t r;
        r.w = cfg_w; r.h = cfg_h; r.st = st; r.sf = sf; r.vl = vl; r.d = d;
        r.fl = fl; r.cn = cn; r.ab = ab; r.rdy = rdy; r.wr = wr; r.wd = wd;
        r.ld = ld; r.fd = fd; r.bs = bs; r.pn = pn; r.er = er;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        logic [16:0] act, exp;
        for (int i = lo; i < hi; i++) begin
            @(negedge wr_clk);
            width_new = 11'(vecs[i].w); height_new = 11'(vecs[i].h);
            start_a = vecs[i].st; sof = vecs[i].sf; pix_valid = vecs[i].vl;
            pix_data = 8'(vecs[i].d); fifo_full = vecs[i].fl;
            line_consumed_a = vecs[i].cn; abort = vecs[i].ab;
            #1;
            act = {ifa.pix_ready, ifa.fifo_wr_en, ifa.fifo_wr_en ? ifa.fifo_wr_data : 8'h00,
                   line_done_a, frame_done_a, busy_a, pending_a, err_a};
            exp = {vecs[i].rdy, vecs[i].wr, 8'(vecs[i].wd), vecs[i].ld, vecs[i].fd,
                   vecs[i].bs, 3'(vecs[i].pn), vecs[i].er};
            check($sformatf("vec%0d {rdy,wr,data,ld,fd,busy,pend,err}", i), 32'(act), 32'(exp));
        end
        @(negedge wr_clk);
        start_a = 1'b0; sof = 1'b0; pix_valid = 1'b0; fifo_full = 1'b0;
        line_consumed_a = 1'b0; abort = 1'b0;
    endtask

    task automatic consume_a(input int exp_pend, input logic exp_err);
        @(negedge wr_clk); line_consumed_a = 1'b1;
        @(negedge wr_clk); line_consumed_a = 1'b0;
        #1;
        check("consume_a pending", 32'(pending_a), 32'(exp_pend));
        check("consume_a err", 32'(err_a), 32'(exp_err));
    endtask

    task automatic stream_b(input int ncyc, input logic do_cons);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge wr_clk);
            pix_valid = (nb < 8); pix_data = 8'(nb); sof = (nb == 0);
            line_consumed_b = do_cons && (c == 0);
            #1;
            if (do_cons && c == 1) check("t2 pending after consume", 32'(pending_b), 1);
            if (ifb.fifo_wr_en) begin
                check("t2 wr_data order", 32'(ifb.fifo_wr_data), 32'(nb));
                nb++;
            end
            if (frame_done_b) fd_b++;
        end
        @(negedge wr_clk);
        pix_valid = 1'b0; sof = 1'b0; line_consumed_b = 1'b0;
    endtask

    initial begin
        int t1_end, t3_end;

        // Nominal frame 4x3 with one junk pixel before sof.
        cfg_w = 4; cfg_h = 3;
        v(1,0,0,0,  0,0,0, 0,0,0, 0,0,0,0,0);
        v(0,0,1,99, 0,0,0, 1,0,0, 0,0,1,0,0);
        v(0,1,1,0,  0,0,0, 0,0,0, 0,0,1,0,0);
        v(0,1,1,0,  0,0,0, 0,0,0, 0,0,1,0,0);
        for (int d = 0; d < 4; d++) v(0, d == 0, 1, d, 0,0,0, 1,1,d, 0,0,1,0,0);
        v(0,0,1,4,  0,0,0, 0,0,0, 1,0,1,0,0);
        for (int d = 4; d < 8; d++) v(0,0,1,d, 0,0,0, 1,1,d, 0,0,1,1,0);
        v(0,0,1,8,  0,0,0, 0,0,0, 1,0,1,1,0);
        for (int d = 8; d < 12; d++) v(0,0,1,d, 0,0,0, 1,1,d, 0,0,1,2,0);
        v(0,0,0,0,  0,0,0, 0,0,0, 1,1,0,2,0);
        v(0,0,0,0,  0,0,0, 0,0,0, 0,0,0,3,0);
        t1_end = vecs.size();

        // fifo_full for 5 cycles while pixel 2 of an 8-wide line is offered.
        cfg_w = 8; cfg_h = 1;
        v(1,0,0,0,  0,0,0, 0,0,0, 0,0,0,0,0);
        v(0,1,1,0,  0,0,0, 0,0,0, 0,0,1,0,0);
        v(0,1,1,0,  0,0,0, 0,0,0, 0,0,1,0,0);
        v(0,1,1,0,  0,0,0, 1,1,0, 0,0,1,0,0);
        v(0,0,1,1,  0,0,0, 1,1,1, 0,0,1,0,0);
        for (int k = 0; k < 5; k++) v(0,0,1,2, 1,0,0, 0,0,0, 0,0,1,0,0);
        for (int d = 2; d < 8; d++) v(0,0,1,d, 0,0,0, 1,1,d, 0,0,1,0,0);
        v(0,0,0,0,  0,0,0, 0,0,0, 1,1,0,0,0);
        v(0,0,0,0,  0,0,0, 0,0,0, 0,0,0,1,0);

        // line_done coinciding with line_consumed at pending=1, then a lone consume.
        cfg_w = 1; cfg_h = 1;
        v(1,0,0,0,  0,0,0, 0,0,0, 0,0,0,1,0);
        v(0,1,1,7,  0,0,0, 0,0,0, 0,0,1,1,0);
        v(0,1,1,7,  0,0,0, 0,0,0, 0,0,1,1,0);
        v(0,1,1,7,  0,0,0, 1,1,7, 0,0,1,1,0);
        v(0,0,0,0,  0,1,0, 0,0,0, 1,1,0,1,0);
        v(0,0,0,0,  0,0,0, 0,0,0, 0,0,0,1,0);
        v(0,0,0,0,  0,1,0, 0,0,0, 0,0,0,1,0);
        v(0,0,0,0,  0,0,0, 0,0,0, 0,0,0,0,0);

        // abort after 3 of 6 pixels with a transfer offered, then a clean 6x1 frame.
        cfg_w = 6; cfg_h = 2;
        v(1,0,0,0,  0,0,0, 0,0,0, 0,0,0,0,0);
        v(0,1,1,0,  0,0,0, 0,0,0, 0,0,1,0,0);
        v(0,1,1,0,  0,0,0, 0,0,0, 0,0,1,0,0);
        for (int d = 0; d < 3; d++) v(0, d == 0, 1, d, 0,0,0, 1,1,d, 0,0,1,0,0);
        v(0,0,1,3,  0,0,1, 1,0,0, 0,0,1,0,0);
        v(0,0,1,3,  0,0,0, 0,0,0, 0,0,0,0,0);
        v(0,0,0,0,  0,0,0, 0,0,0, 0,0,0,0,0);
        cfg_w = 6; cfg_h = 1;
        v(1,0,0,0,  0,0,0, 0,0,0, 0,0,0,0,0);
        v(0,1,1,10, 0,0,0, 0,0,0, 0,0,1,0,0);
        v(0,1,1,10, 0,0,0, 0,0,0, 0,0,1,0,0);
        for (int d = 10; d < 16; d++) v(0, d == 10, 1, d, 0,0,0, 1,1,d, 0,0,1,0,0);
        v(0,0,0,0,  0,0,0, 0,0,0, 1,1,0,0,0);
        v(0,0,0,0,  0,0,0, 0,0,0, 0,0,0,1,0);
        t3_end = vecs.size();

        // Reset state.
        repeat (2) @(negedge wr_clk);
        #1;
        check("reset A outputs", 32'({busy_a, line_done_a, frame_done_a, pending_a, err_a,
                                      ifa.fifo_wr_en, ifa.pix_ready}), 0);
        check("reset B outputs", 32'({busy_b, line_done_b, frame_done_b, pending_b, err_b,
                                      ifb.fifo_wr_en, ifb.pix_ready}), 0);
        @(negedge wr_clk); wr_rstn = 1'b1;

        run_vecs(0, t1_end);

        consume_a(2, 1'b0);
        consume_a(1, 1'b0);
        consume_a(0, 1'b0);

        // Credit stall on the MAX_PENDING=2 instance: 2x4 frame.
        @(negedge wr_clk); width_new = 11'd2; height_new = 11'd4; start_b = 1'b1;
        @(negedge wr_clk); start_b = 1'b0;
        stream_b(30, 1'b0);
        check("t2 stall pixels written", 32'(nb), 4);
        check("t2 stall pending", 32'(pending_b), 2);
        check("t2 stall pix_ready", 32'(ifb.pix_ready), 0);
        check("t2 stall busy", 32'(busy_b), 1);
        stream_b(20, 1'b1);
        check("t2 third line pixels", 32'(nb), 6);
        check("t2 third line pending", 32'(pending_b), 2);
        stream_b(20, 1'b1);
        check("t2 frame pixels", 32'(nb), 8);
        check("t2 frame_done count", 32'(fd_b), 1);
        check("t2 busy after frame", 32'(busy_b), 0);
        check("t2 err clean", 32'(err_b), 0);

        run_vecs(t1_end, t3_end);

        // Underflow of pending sets err.
        consume_a(0, 1'b0);
        consume_a(0, 1'b1);

        // start with height 0 is rejected.
        @(negedge wr_clk); width_new = 11'd5; height_new = 11'd0; start_b = 1'b1;
        @(negedge wr_clk); start_b = 1'b0;
        #1;
        check("zero height busy", 32'(busy_b), 0);
        check("zero height err", 32'(err_b), 1);
        repeat (3) begin
            @(negedge wr_clk); pix_valid = 1'b1; pix_data = 8'h55;
            #1;
            check("zero height no wr_en", 32'(ifb.fifo_wr_en), 0);
        end
        pix_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ds_line_wr_ctrl.md
Name: ds_line_wr_ctrl

Overview:
Write-side sequencer for the downsample-path async line FIFO, running in the wr_clk domain. It takes the downsampler's pixel stream and drives the FIFO write port one line of width_new pixels at a time, for height_new lines per frame. It tracks how many complete lines are buffered and not yet consumed, and holds off a new line while that count is at its limit. Frame and line completion are reported as single-cycle pulses.

Parameters:
WIDTH, 8, pixel data width
CW, 11, width_new / height_new / pixel-counter width
MAX_PENDING, 4, maximum completed-but-unconsumed lines held in the FIFO
PW, 3, pending-line counter width; must hold MAX_PENDING

Ports:
wr_clk  in  1  write-domain clock
wr_rstn  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse: arm a frame and latch the configuration
abort  in  1  1-cycle pulse: return to IDLE immediately
width_new  in  CW  pixels per line, sampled on start
height_new  in  CW  lines per frame, sampled on start
sof  in  1  start-of-frame marker from the downsampler, qualified by pix_valid
pix_valid  in  1  downsampler pixel valid
pix_data  in  WIDTH  downsampler pixel
pix_ready  out  1  controller accepts a pixel this cycle
fifo_full  in  1  FIFO full flag
fifo_wr_en  out  1  FIFO write enable
fifo_wr_data  out  WIDTH  FIFO write data
line_consumed  in  1  1-cycle pulse, already synchronised to wr_clk: reader finished one line
line_done  out  1  1-cycle pulse: last pixel of a line written
frame_done  out  1  1-cycle pulse: last line of the frame written
busy  out  1  state is not IDLE
pending  out  PW  number of completed, unconsumed lines
err  out  1  sticky error flag; cleared only by reset

Behaviour:
Reset values:
- State IDLE.
- All outputs 0; pending 0; err 0.
- Latched configuration and pixel/line counters 0.

FSM states: IDLE, WAIT_SOF, LINE_WAIT, WRITE.
- IDLE: on start with width_new != 0 and height_new != 0, latch both values and go to WAIT_SOF.
- IDLE: on start with either value equal to 0, stay in IDLE and set err.
- WAIT_SOF: pix_ready = 1 and pixels are dropped (no FIFO write) until the cycle with pix_valid && sof, then go to LINE_WAIT.
- The sof pixel itself is not dropped: it is held by pix_ready = 0 in that cycle and written as pixel 0 of line 0.
- LINE_WAIT: pix_ready = 0; go to WRITE when pending < MAX_PENDING.
- WRITE: pix_ready = !fifo_full. A transfer is pix_valid && pix_ready.
- On each transfer, pix_cnt increments.
- On the transfer with pix_cnt == width_lat-1: pix_cnt clears, line_done pulses in the next cycle, and line_cnt increments.
- After that transfer: if line_cnt == height_lat-1, frame_done pulses together with line_done and the FSM goes to IDLE; otherwise it goes to LINE_WAIT.
- sof seen while in WRITE or LINE_WAIT sets err; the pixel is still written as normal data.

FIFO port:
- fifo_wr_en = transfer, combinational, zero latency.
- fifo_wr_data = pix_data.
- No write is issued while fifo_full is 1.

pending counter:
- +1 on the line_done cycle, -1 on line_consumed.
- Both in the same cycle: unchanged.
- line_consumed with pending == 0: pending stays 0 and err is set.
- pending never exceeds MAX_PENDING, guaranteed by LINE_WAIT.

abort:
- Next cycle: IDLE, pix_cnt and line_cnt cleared, no line_done or frame_done.
- pending is kept, because lines already in the FIFO remain valid.
- abort has priority over start and over a transfer in the same cycle; that transfer is not written.

start outside IDLE: ignored.

Asynchronous reset mid-line: everything clears immediately. The FIFO must be reset by the same reset.

Width rules: counters are CW bits, compared against width_lat-1 and height_lat-1. All counting is unsigned; no wrap-around can occur within a frame.

Test Plan:
1. Nominal frame: start with width_new=4, height_new=3, MAX_PENDING=4; sof followed by 12 continuous pixels 0..11; line_consumed never asserted -> 12 fifo_wr_en cycles with data 0..11; line_done pulses after pixels 3, 7 and 11; frame_done coincides with the third line_done; pending=3; busy drops the next cycle.
2. Credit stall: MAX_PENDING=2, width_new=2, height_new=4, no line_consumed -> after 2 lines pix_ready stays 0 in LINE_WAIT; one line_consumed pulse -> pending goes 2→1 and the third line proceeds.
3. fifo_full in the middle of a line: fifo_full=1 for 5 cycles during pixel 2 of width 8 -> pix_ready=0 and no wr_en for those cycles; then pixels resume in order with none lost or duplicated.
4. Simultaneous events: line_done and line_consumed in the same cycle with pending=1 -> pending stays 1. A line_consumed pulse with pending=0 -> pending=0 and err=1.
5. abort mid-line after 3 of 6 pixels, with a transfer presented in the same cycle -> that pixel is not written; IDLE the next cycle; no line_done; a new start and frame then run cleanly from pixel 0.
6. start with height_new=0 -> state stays IDLE, busy=0, err=1. Pixels presented before sof in WAIT_SOF -> no wr_en.
